// File: rtl/mmul_feed_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : mmul_feed_sequencer
//  Purpose  : Read-side sequencer for the west/north ping-pong buffers.
//             Waits for a bank to be reported fully written, then reads it
//             out one address per cycle: west ports A and B, and north port A.
//             It generates feed-valid strobes that line up with the BRAM read
//             latency and drives the systolic array enable. When the array
//             and the accumulator report completion, it hands the bank back
//             to the writer.
//  Ports    : clk, rst_n (synchronous, active-low)
//             bank_ready_i/_sel_i  - bank fully written (pulse + index)
//             systolic_finish_i    - array consumed feed (level)
//             acc_done_i           - accumulator done (rising edge used)
//             rd_bank_sel_o        - bank being read
//             w_rd_en_o, w_addra_o, w_addrb_o - west read port A/B
//             n_rd_en_o, n_addra_o - north read port A
//             w_feed_valid_o, n_feed_valid_o - read data valid strobes
//             enable_matmul_o      - systolic array enable
//             bank_release_o/_sel_o - bank free for writing (pulse + index)
//             busy_o, err_overflow_o - status / sticky overflow
//  Revision : 1.0 - initial release
// ============================================================================
module mmul_feed_sequencer #(
    parameter int ADDR_WIDTH = 4,
    parameter int W_COL_X    = 4,
    parameter int N_COL_X    = 4,
    parameter int RD_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  bank_ready_i,
    input  logic                  bank_ready_sel_i,
    input  logic                  systolic_finish_i,
    input  logic                  acc_done_i,
    output logic                  rd_bank_sel_o,
    output logic                  w_rd_en_o,
    output logic [ADDR_WIDTH-1:0] w_addra_o,
    output logic [ADDR_WIDTH-1:0] w_addrb_o,
    output logic                  n_rd_en_o,
    output logic [ADDR_WIDTH-1:0] n_addra_o,
    output logic                  w_feed_valid_o,
    output logic                  n_feed_valid_o,
    output logic                  enable_matmul_o,
    output logic                  bank_release_o,
    output logic                  bank_release_sel_o,
    output logic                  busy_o,
    output logic                  err_overflow_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FEED    = 3'd1,
        S_DRAIN   = 3'd2,
        S_WAIT    = 3'd3,
        S_RELEASE = 3'd4
    } state_t;

    localparam logic [7:0]            C_K_LAST   = 8'(W_COL_X - 1);
    localparam logic [7:0]            C_N_LIMIT  = 8'(N_COL_X);
    localparam logic [7:0]            C_D_LAST   = 8'(RD_LATENCY - 1);
    localparam logic [ADDR_WIDTH-1:0] C_B_OFFSET = ADDR_WIDTH'(W_COL_X);

    state_t                state_q, state_d;
    logic [1:0]            pending_q, pending_d;
    logic                  next_bank_q, next_bank_d;
    logic                  rd_bank_q, rd_bank_d;
    logic [7:0]            k_q, k_d;
    logic [7:0]            dcnt_q, dcnt_d;
    logic                  fin_seen_q, fin_seen_d;
    logic                  acc_seen_q, acc_seen_d;
    logic                  acc_done_q;
    logic                  err_q, err_d;
    logic [RD_LATENCY-1:0] w_vld_q;
    logic [RD_LATENCY-1:0] n_vld_q;

    logic                  acc_rise;
    logic                  fin_now;
    logic                  acc_now;
    logic                  feeding;
    logic                  n_active;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        next_bank_d = next_bank_q;
        rd_bank_d   = rd_bank_q;
        k_d         = k_q;
        dcnt_d      = dcnt_q;
        fin_seen_d  = fin_seen_q;
        acc_seen_d  = acc_seen_q;
        err_d       = err_q;

        acc_rise = acc_done_i & ~acc_done_q;
        // Completion events are remembered once seen so they may arrive
        // in either order or together.
        fin_now  = fin_seen_q | systolic_finish_i;
        acc_now  = acc_seen_q | acc_rise;

        case (state_q)
            S_IDLE: begin
                if (pending_q[next_bank_q]) begin
                    state_d   = S_FEED;
                    rd_bank_d = next_bank_q;
                    k_d       = 8'd0;
                end
            end
            S_FEED: begin
                if (k_q == C_K_LAST) begin
                    state_d = S_DRAIN;
                    dcnt_d  = 8'd0;
                end else begin
                    k_d = k_q + 8'd1;
                end
            end
            S_DRAIN: begin
                if (dcnt_q == C_D_LAST) begin
                    state_d    = S_WAIT;
                    fin_seen_d = 1'b0;
                    acc_seen_d = 1'b0;
                end else begin
                    dcnt_d = dcnt_q + 8'd1;
                end
            end
            S_WAIT: begin
                if (fin_now && acc_now) begin
                    state_d    = S_RELEASE;
                    fin_seen_d = 1'b0;
                    acc_seen_d = 1'b0;
                end else begin
                    fin_seen_d = fin_now;
                    acc_seen_d = acc_now;
                end
            end
            S_RELEASE: begin
                pending_d[rd_bank_q] = 1'b0;
                next_bank_d          = ~next_bank_q;
                state_d              = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Applied after the release clear so a simultaneous set wins.
        if (bank_ready_i) begin
            if (pending_q[bank_ready_sel_i]) begin
                err_d = 1'b1;
            end
            pending_d[bank_ready_sel_i] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            pending_q   <= 2'b00;
            next_bank_q <= 1'b0;
            rd_bank_q   <= 1'b0;
            k_q         <= 8'd0;
            dcnt_q      <= 8'd0;
            fin_seen_q  <= 1'b0;
            acc_seen_q  <= 1'b0;
            acc_done_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            next_bank_q <= next_bank_d;
            rd_bank_q   <= rd_bank_d;
            k_q         <= k_d;
            dcnt_q      <= dcnt_d;
            fin_seen_q  <= fin_seen_d;
            acc_seen_q  <= acc_seen_d;
            acc_done_q  <= acc_done_i;
            err_q       <= err_d;
        end
    end

    // ------------------------------------------------------------------
    // Read-valid pipelines: strobe emerges RD_LATENCY cycles after enable
    // ------------------------------------------------------------------
    generate
        if (RD_LATENCY == 1) begin : g_pipe_single
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    w_vld_q <= '0;
                    n_vld_q <= '0;
                end else begin
                    w_vld_q <= w_rd_en_o;
                    n_vld_q <= n_rd_en_o;
                end
            end
        end else begin : g_pipe_multi
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    w_vld_q <= '0;
                    n_vld_q <= '0;
                end else begin
                    w_vld_q <= {w_vld_q[RD_LATENCY-2:0], w_rd_en_o};
                    n_vld_q <= {n_vld_q[RD_LATENCY-2:0], n_rd_en_o};
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign feeding  = (state_q == S_FEED);
    assign n_active = feeding && (k_q < C_N_LIMIT);

    assign rd_bank_sel_o      = rd_bank_q;
    assign w_rd_en_o          = feeding;
    assign w_addra_o          = feeding ? k_q[ADDR_WIDTH-1:0] : '0;
    assign w_addrb_o          = feeding ? (C_B_OFFSET + k_q[ADDR_WIDTH-1:0]) : '0;
    assign n_rd_en_o          = n_active;
    assign n_addra_o          = n_active ? k_q[ADDR_WIDTH-1:0] : '0;
    assign w_feed_valid_o     = w_vld_q[RD_LATENCY-1];
    assign n_feed_valid_o     = n_vld_q[RD_LATENCY-1];
    // The last west strobe lands in the final drain cycle, so valid
    // followed by S_WAIT forms one contiguous enable window.
    assign enable_matmul_o    = w_vld_q[RD_LATENCY-1] || (state_q == S_WAIT);
    assign bank_release_o     = (state_q == S_RELEASE);
    assign bank_release_sel_o = (state_q == S_RELEASE) ? rd_bank_q : 1'b0;
    assign busy_o             = (state_q != S_IDLE);
    assign err_overflow_o     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mmul_feed_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mmul_feed_sequencer
//  Purpose  : Self-checking bench for mmul_feed_sequencer. A timeline model
//             tracks each bank by the cycle its feed starts and derives every
//             output from the offset into that feed. Directed scenarios pin
//             the model with literal values, followed by a randomized run.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mmul_feed_sequencer;

    localparam int AW = 4;
    localparam int W  = 4;
    localparam int N  = 4;
    localparam int L  = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic bank_ready = 1'b0;
    logic bank_ready_sel = 1'b0;
    logic systolic_finish = 1'b0;
    logic acc_done = 1'b0;
    logic rd_bank_sel, w_rd_en, n_rd_en, w_feed_valid, n_feed_valid;
    logic enable_matmul, bank_release, bank_release_sel, busy, err_overflow;
    logic [AW-1:0] w_addra, w_addrb, n_addra;

    int n_cmp = 0;
    int n_err = 0;

    mmul_feed_sequencer #(
        .ADDR_WIDTH (AW),
        .W_COL_X    (W),
        .N_COL_X    (N),
        .RD_LATENCY (L)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .bank_ready_i       (bank_ready),
        .bank_ready_sel_i   (bank_ready_sel),
        .systolic_finish_i  (systolic_finish),
        .acc_done_i         (acc_done),
        .rd_bank_sel_o      (rd_bank_sel),
        .w_rd_en_o          (w_rd_en),
        .w_addra_o          (w_addra),
        .w_addrb_o          (w_addrb),
        .n_rd_en_o          (n_rd_en),
        .n_addra_o          (n_addra),
        .w_feed_valid_o     (w_feed_valid),
        .n_feed_valid_o     (n_feed_valid),
        .enable_matmul_o    (enable_matmul),
        .bank_release_o     (bank_release),
        .bank_release_sel_o (bank_release_sel),
        .busy_o             (busy),
        .err_overflow_o     (err_overflow)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Timeline model
    // ------------------------------------------------------------------
    int cyc = 0;
    int m_s = 0;           // cycle in which the active bank's feed starts
    bit m_ok = 0;
    bit m_pend [2];
    bit m_nb, m_err, m_act, m_rel, m_fin, m_acc, m_accp, m_bank;

    task automatic model_compare();
        int o;
        bit e_rd, e_nrd, e_wv, e_nv, e_wait;
        o      = cyc - m_s;
        e_rd   = m_act && (o < W);
        e_nrd  = e_rd && (o < N);
        e_wv   = m_act && (o >= L) && (o < W + L);
        e_nv   = m_act && (o >= L) && (o < N + L);
        e_wait = m_act && (o >= W + L);
        chk("rd_bank_sel", rd_bank_sel, m_bank);
        chk("w_rd_en", w_rd_en, e_rd);
        chk("w_addra", w_addra, e_rd ? o : 0);
        chk("w_addrb", w_addrb, e_rd ? W + o : 0);
        chk("n_rd_en", n_rd_en, e_nrd);
        chk("n_addra", n_addra, e_nrd ? o : 0);
        chk("w_feed_valid", w_feed_valid, e_wv);
        chk("n_feed_valid", n_feed_valid, e_nv);
        chk("enable_matmul", enable_matmul, e_wv || e_wait);
        chk("bank_release", bank_release, m_rel);
        chk("bank_release_sel", bank_release_sel, m_rel ? m_bank : 1'b0);
        chk("busy", busy, m_act || m_rel);
        chk("err_overflow", err_overflow, m_err);
    endtask

    task automatic model_step();
        bit old [2];
        if (!rst_n) begin
            m_ok = 1; m_pend[0] = 0; m_pend[1] = 0; m_nb = 0; m_err = 0;
            m_act = 0; m_rel = 0; m_fin = 0; m_acc = 0; m_accp = 0; m_bank = 0;
        end else begin
            old = m_pend;
            if (m_rel) begin
                m_pend[m_bank] = 0;
                m_nb  = ~m_nb;
                m_rel = 0;
            end else if (m_act) begin
                if (cyc - m_s >= W + L) begin
                    m_fin = m_fin | systolic_finish;
                    m_acc = m_acc | (acc_done & ~m_accp);
                    if (m_fin && m_acc) begin
                        m_act = 0; m_rel = 1; m_fin = 0; m_acc = 0;
                    end
                end
            end else if (m_pend[m_nb]) begin
                m_act  = 1;
                m_bank = m_nb;
                m_s    = cyc + 1;
            end
            if (bank_ready) begin
                if (old[bank_ready_sel]) m_err = 1;
                m_pend[bank_ready_sel] = 1;
            end
            m_accp = acc_done;
        end
        cyc++;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (m_ok) model_compare();
            @(posedge clk);
            model_step();
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_ready(input bit sel);
        bank_ready = 1'b1; bank_ready_sel = sel;
        tick(1);
        bank_ready = 1'b0;
    endtask

    task automatic done_inputs(input bit v);
        systolic_finish = v; acc_done = v;
    endtask

    initial begin
        rst_n = 1'b0;
        tick(3);
        chk("reset_busy", busy, 0);
        chk("reset_en", enable_matmul, 0);
        rst_n = 1'b1;
        tick(2);

        // Single bank 0: addresses, valid lag, single release pulse
        pulse_ready(0);
        chk("t2_latency", w_rd_en, 0);
        for (int k = 0; k < W; k++) begin
            tick(1);
            chk("t2_wrd", w_rd_en, 1);
            chk("t2_addra", w_addra, k);
            chk("t2_addrb", w_addrb, 4 + k);
            chk("t2_naddr", n_addra, k);
            chk("t2_wvalid", w_feed_valid, (k >= 2) ? 1 : 0);
        end
        tick(1);
        chk("t2_drain_valid", w_feed_valid, 1);
        tick(1);
        chk("t2_drain_valid2", w_feed_valid, 1);
        tick(1);
        chk("t2_wait_valid", w_feed_valid, 0);
        chk("t2_wait_en", enable_matmul, 1);
        done_inputs(1);
        tick(1);
        chk("t2_release", bank_release, 1);
        chk("t2_release_sel", bank_release_sel, 0);
        chk("t2_en_drop", enable_matmul, 0);
        done_inputs(0);
        tick(1);
        chk("t2_release_once", bank_release, 0);
        chk("t2_idle", busy, 0);

        // acc_done rises 3 cycles before systolic_finish (bank 1)
        pulse_ready(1);
        tick(7);
        acc_done = 1'b1;
        tick(3);
        chk("t4_no_rel_yet", bank_release, 0);
        chk("t4_en_hold", enable_matmul, 1);
        systolic_finish = 1'b1;
        tick(1);
        chk("t4_release", bank_release, 1);
        chk("t4_release_sel", bank_release_sel, 1);
        chk("t4_en_drop", enable_matmul, 0);
        done_inputs(0);
        tick(2);

        // Back-to-back: bank 1 ready during bank 0 feed
        pulse_ready(0);
        tick(2);
        pulse_ready(1);
        tick(4);
        done_inputs(1);
        tick(1);
        chk("t3_rel0", bank_release, 1);
        chk("t3_rel0_sel", bank_release_sel, 0);
        done_inputs(0);
        tick(1);
        chk("t3_idle_gap", busy, 0);
        tick(1);
        chk("t3_feed1", w_rd_en, 1);
        chk("t3_feed1_bank", rd_bank_sel, 1);
        tick(6);
        done_inputs(1);
        tick(1);
        chk("t3_rel1_sel", bank_release_sel, 1);
        done_inputs(0);
        tick(2);

        // Overflow: bank 0 ready twice without a release
        pulse_ready(0);
        tick(1);
        pulse_ready(0);
        chk("t5_overflow", err_overflow, 1);
        tick(5);
        done_inputs(1);
        tick(1);
        chk("t5_rel", bank_release, 1);
        done_inputs(0);
        tick(3);
        chk("t5_single_feed", busy, 0);
        chk("t5_sticky", err_overflow, 1);

        // Reset held mid-feed
        pulse_ready(1);
        tick(2);
        chk("t1_pre_feed", w_rd_en, 1);
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk("t1_busy", busy, 0);
            chk("t1_wvalid", w_feed_valid, 0);
            chk("t1_release", bank_release, 0);
            chk("t1_err", err_overflow, 0);
        end
        rst_n = 1'b1;
        tick(2);
        chk("t1_after", busy, 0);

        // Out-of-order readiness: bank 1 waits for bank 0
        pulse_ready(1);
        tick(3);
        chk("t6_stay_idle", busy, 0);
        pulse_ready(0);
        tick(7);
        done_inputs(1);
        tick(1);
        chk("t6_rel0_sel", bank_release_sel, 0);
        chk("t6_rel0", bank_release, 1);
        done_inputs(0);
        tick(2);
        chk("t6_feed1", w_rd_en, 1);
        chk("t6_feed1_bank", rd_bank_sel, 1);
        tick(6);
        done_inputs(1);
        tick(1);
        chk("t6_rel1", bank_release, 1);
        chk("t6_rel1_sel", bank_release_sel, 1);
        done_inputs(0);
        tick(2);

        // Randomized run against the model
        for (int i = 0; i < 3000; i++) begin
            bank_ready      = ($urandom % 6) == 0;
            bank_ready_sel  = 1'($urandom % 2);
            systolic_finish = ($urandom % 3) == 0;
            if (($urandom % 4) == 0) acc_done = ~acc_done;
            rst_n           = ($urandom % 400) != 0;
            tick(1);
        end
        rst_n = 1'b1;
        bank_ready = 1'b0;
        done_inputs(0);
        tick(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
